// File: rtl/lfu_finder_param.sv
// LFU victim finder for a BUF_NUM-entry buffer pool: saturating per-buffer
// frequency counters with halving-based aging, lock mask and status pulses.
module lfu_finder_param #(
    parameter int BUF_NUM  = 4,
    parameter int BUF_BIT  = 2,
    parameter int CNT_BIT  = 2,
    parameter int INIT_CNT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ref_vld,
    input  logic [BUF_BIT-1:0] ref_idx,
    input  logic               new_vld,
    input  logic [BUF_NUM-1:0] lock_mask,
    output logic [BUF_BIT-1:0] victim_nxt,
    output logic [BUF_BIT-1:0] buf_num_replc,
    output logic               replc_vld,
    output logic               replc_err,
    output logic               age_pulse
);

    localparam logic [CNT_BIT-1:0] CNT_MAX  = '1;
    localparam logic [CNT_BIT-1:0] CNT_INIT = CNT_BIT'(INIT_CNT);
    localparam logic [CNT_BIT-1:0] CNT_AGED = (CNT_MAX >> 1) + CNT_BIT'(1);

    logic [CNT_BIT-1:0] cnt     [BUF_NUM];
    logic [CNT_BIT-1:0] cnt_nxt [BUF_NUM];
    logic [CNT_BIT-1:0] best_cnt;
    logic               victim_vld;
    logic               ref_use;
    logic               age_nxt;
    logic               do_replc;

    // Lowest-index minimum over unlocked entries; strict '<' keeps the first tie.
    // NOTE: always_comb variables get a default first so no latch is inferred.
    always_comb begin
        victim_nxt = '0;
        victim_vld = 1'b0;
        best_cnt   = CNT_MAX;
        for (int i = 0; i < BUF_NUM; i++) begin
            if (!lock_mask[i] && (!victim_vld || cnt[i] < best_cnt)) begin
                victim_vld = 1'b1;
                best_cnt   = cnt[i];
                victim_nxt = BUF_BIT'(i);
            end
        end
    end

    assign do_replc = new_vld && victim_vld;
    // A hit on the buffer being replaced is discarded, so it cannot trigger aging.
    assign ref_use  = ref_vld && !(do_replc && ref_idx == victim_nxt);

    always_comb begin
        age_nxt = 1'b0;
        for (int i = 0; i < BUF_NUM; i++) begin
            cnt_nxt[i] = cnt[i];
        end
        if (ref_use) begin
            if (cnt[ref_idx] != CNT_MAX) begin
                cnt_nxt[ref_idx] = cnt[ref_idx] + CNT_BIT'(1);
            end else begin
                age_nxt = 1'b1;
                for (int i = 0; i < BUF_NUM; i++) begin
                    if (BUF_BIT'(i) == ref_idx) begin
                        cnt_nxt[i] = CNT_AGED;
                    end else if ((cnt[i] >> 1) == '0) begin
                        cnt_nxt[i] = CNT_BIT'(1);
                    end else begin
                        cnt_nxt[i] = cnt[i] >> 1;
                    end
                end
            end
        end
        if (do_replc) begin
            cnt_nxt[victim_nxt] = CNT_INIT;
        end
    end

    // NOTE: the counter array is reset explicitly; a zero or stale count would
    // break the 1..CNT_MAX invariant the victim search relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < BUF_NUM; i++) begin
                cnt[i] <= CNT_INIT;
            end
            buf_num_replc <= '0;
            replc_vld     <= 1'b0;
            replc_err     <= 1'b0;
            age_pulse     <= 1'b0;
        end else begin
            for (int i = 0; i < BUF_NUM; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            if (do_replc) begin
                buf_num_replc <= victim_nxt;
            end
            replc_vld <= do_replc;
            replc_err <= new_vld && !victim_vld;
            age_pulse <= age_nxt;
        end
    end

endmodule

// File: tb/tb_lfu_finder_param.sv
// Self-checking bench for lfu_finder_param: directed scenarios plus randomized
// traffic, all checked against an integer-array frequency model.
module tb_lfu_finder_param;

    localparam int N    = 4;
    localparam int MAX  = 3;
    localparam int INIT = 1;

    logic       clk = 1'b0;
    logic       rst;
    logic       ref_vld;
    logic [1:0] ref_idx;
    logic       new_vld;
    logic [3:0] lock_mask;
    logic [1:0] victim_nxt;
    logic [1:0] buf_num_replc;
    logic       replc_vld;
    logic       replc_err;
    logic       age_pulse;

    int checks = 0;
    int errors = 0;

    int m_cnt [N];
    int m_replc;

    lfu_finder_param #(.BUF_NUM(4), .BUF_BIT(2), .CNT_BIT(2), .INIT_CNT(1)) dut (
        .clk          (clk),
        .rst          (rst),
        .ref_vld      (ref_vld),
        .ref_idx      (ref_idx),
        .new_vld      (new_vld),
        .lock_mask    (lock_mask),
        .victim_nxt   (victim_nxt),
        .buf_num_replc(buf_num_replc),
        .replc_vld    (replc_vld),
        .replc_err    (replc_err),
        .age_pulse    (age_pulse)
    );

    always #50 clk = ~clk;

    // Smallest count among unlocked buffers, then the first buffer holding it; -1 if none.
    function automatic int m_victim(input logic [3:0] lm);
        int lo = MAX + 1;
        int v  = -1;
        for (int i = 0; i < N; i++) if (!lm[i] && m_cnt[i] < lo) lo = m_cnt[i];
        for (int i = 0; i < N; i++) if (v < 0 && !lm[i] && m_cnt[i] == lo) v = i;
        return v;
    endfunction

    // One clock of stimulus starting at a negedge; checks victim_nxt before the
    // edge and the registered outputs just after it.
    task automatic step(input logic rv, input int ri, input logic nv, input logic [3:0] lm);
        int v;
        int nxt [N];
        int want_v;
        logic exp_age;
        ref_vld   = rv;
        ref_idx   = 2'(ri);
        new_vld   = nv;
        lock_mask = lm;
        #1;
        v      = m_victim(lm);
        want_v = (v < 0) ? 0 : v;
        checks++;
        if (victim_nxt !== 2'(want_v)) begin
            errors++;
            $display("FAIL step_victim_nxt got %0d want %0d (lock %b)", victim_nxt, want_v, lm);
        end
        nxt     = m_cnt;
        exp_age = 1'b0;
        if (rv && !(nv && v == ri)) begin
            if (m_cnt[ri] < MAX) nxt[ri] = m_cnt[ri] + 1;
            else begin
                exp_age = 1'b1;
                for (int j = 0; j < N; j++)
                    nxt[j] = (j == ri) ? MAX / 2 + 1 : ((m_cnt[j] / 2 < 1) ? 1 : m_cnt[j] / 2);
            end
        end
        if (nv && v >= 0) begin
            nxt[v]  = INIT;
            m_replc = v;
        end
        @(posedge clk);
        #1;
        m_cnt = nxt;
        checks++;
        if (replc_vld !== (nv && v >= 0)) begin
            errors++;
            $display("FAIL replc_vld got %b want %b", replc_vld, (nv && v >= 0));
        end
        checks++;
        if (replc_err !== (nv && v < 0)) begin
            errors++;
            $display("FAIL replc_err got %b want %b", replc_err, (nv && v < 0));
        end
        checks++;
        if (age_pulse !== exp_age) begin
            errors++;
            $display("FAIL age_pulse got %b want %b", age_pulse, exp_age);
        end
        checks++;
        if (buf_num_replc !== 2'(m_replc)) begin
            errors++;
            $display("FAIL buf_num_replc got %0d want %0d", buf_num_replc, m_replc);
        end
        ref_vld   = 1'b0;
        new_vld   = 1'b0;
        ref_idx   = 2'($urandom_range(0, 3));
        lock_mask = 4'($urandom_range(0, 15));
        @(negedge clk);
    endtask

    // Sweeps every lock mask; victim_nxt is combinational so no clock is needed.
    task automatic probe();
        int v;
        for (int m = 0; m < 16; m++) begin
            lock_mask = 4'(m);
            #1;
            v = m_victim(4'(m));
            checks++;
            if (victim_nxt !== 2'((v < 0) ? 0 : v)) begin
                errors++;
                $display("FAIL probe_victim lock %b got %0d want %0d", 4'(m), victim_nxt, (v < 0) ? 0 : v);
            end
        end
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ref_vld = 1'b1;
        ref_idx = 2'($urandom_range(0, 3));
        new_vld = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ref_vld = 1'b0;
        new_vld = 1'b0;
        for (int i = 0; i < N; i++) m_cnt[i] = INIT;
        m_replc = 0;
        checks++;
        if ({buf_num_replc, replc_vld, replc_err, age_pulse} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b want 00000", {buf_num_replc, replc_vld, replc_err, age_pulse});
        end
        @(negedge clk);
        probe();
    endtask

    task automatic test_alloc();
        test_reset();
        step(1'b0, 0, 1'b1, 4'b0000);
        checks++;
        if (buf_num_replc !== 2'd0) begin
            errors++;
            $display("FAIL t1_victim got %0d want 0", buf_num_replc);
        end
        probe();
    endtask

    task automatic test_ref_then_alloc();
        test_reset();
        step(1'b1, 0, 1'b0, 4'b0000);
        step(1'b1, 0, 1'b0, 4'b0000);
        step(1'b1, 1, 1'b0, 4'b0000);
        step(1'b0, 0, 1'b1, 4'b0000);
        checks++;
        if (buf_num_replc !== 2'd2) begin
            errors++;
            $display("FAIL t2_victim got %0d want 2", buf_num_replc);
        end
        probe();
    endtask

    task automatic test_aging();
        // Continues from counters {3,2,1,1}.
        step(1'b1, 0, 1'b0, 4'b0000);
        lock_mask = 4'b0000;
        #1;
        checks++;
        if (age_pulse !== 1'b1 || victim_nxt !== 2'd1) begin
            errors++;
            $display("FAIL t3_aging got pulse %b victim %0d want pulse 1 victim 1", age_pulse, victim_nxt);
        end
        probe();
        step(1'b0, 0, 1'b0, 4'b0000);
    endtask

    task automatic test_lock();
        test_reset();
        step(1'b1, 2, 1'b0, 4'b0000);
        step(1'b1, 3, 1'b0, 4'b0000);
        step(1'b1, 3, 1'b0, 4'b0000);
        step(1'b0, 0, 1'b1, 4'b0011);
        checks++;
        if (buf_num_replc !== 2'd2) begin
            errors++;
            $display("FAIL t4_locked_victim got %0d want 2", buf_num_replc);
        end
        probe();
    endtask

    task automatic test_all_locked();
        test_reset();
        step(1'b0, 0, 1'b1, 4'b1011);
        step(1'b1, 3, 1'b1, 4'b1111);
        checks++;
        if (replc_err !== 1'b1 || buf_num_replc !== 2'd2) begin
            errors++;
            $display("FAIL t5_all_locked got err %b replc %0d want err 1 replc 2", replc_err, buf_num_replc);
        end
        // cnt3 is now 2, so one more hit must saturate without aging.
        step(1'b1, 3, 1'b0, 4'b0000);
        step(1'b1, 3, 1'b0, 4'b0000);
        probe();
    endtask

    task automatic test_ref_victim_then_reset();
        int v;
        test_reset();
        step(1'b1, 1, 1'b0, 4'b0000);
        step(1'b1, 1, 1'b0, 4'b0000);
        step(1'b1, 0, 1'b0, 4'b0000);
        v = m_victim(4'b0001);
        step(1'b1, v, 1'b1, 4'b0001);
        probe();
        step(1'b1, 1, 1'b1, 4'b0000);
        test_reset();
    endtask

    task automatic test_back_to_back();
        test_reset();
        for (int k = 0; k < 400; k++) begin
            step(1'($urandom_range(0, 3) != 0), $urandom_range(0, 3),
                 1'($urandom_range(0, 2) == 0), 4'($urandom_range(0, 15) & $urandom_range(0, 15)));
            if (k % 50 == 25) probe();
            if (k == 200) test_reset();
        end
    endtask

    initial begin
        rst       = 1'b0;
        ref_vld   = 1'b0;
        ref_idx   = 2'd0;
        new_vld   = 1'b0;
        lock_mask = 4'b0000;
        @(negedge clk);
        test_reset();
        test_alloc();
        test_ref_then_alloc();
        test_aging();
        test_lock();
        test_all_locked();
        test_ref_victim_then_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
